// File: rtl/stage_mem_lsu_pkg.sv
// Shared constants for the memory-stage load/store unit: width codes and FSM states.
package stage_mem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/stage_mem_lsu_align.sv
// Byte-lane alignment: strobe/replicate for scalar stores, extract/extend for scalar loads.
module stage_mem_lsu_align
  import stage_mem_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [2:0]       st_func3,
  input  logic [OFF_W-1:0] st_offset,
  input  logic [XLEN-1:0]  st_data,
  output logic [XLEN-1:0]  st_wdata,
  output logic [NB-1:0]    st_wstrb,
  input  logic [2:0]       ld_func3,
  input  logic [OFF_W-1:0] ld_offset,
  input  logic [XLEN-1:0]  ld_raw,
  output logic [XLEN-1:0]  ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wdata = st_data;
    st_wstrb = '1;
    case (st_func3)
      F3_B: begin
        st_wdata = {NB{st_data[7:0]}};
        st_wstrb = NB'(1) << st_offset;
      end
      F3_H: begin
        st_wdata = {(NB / 2){st_data[15:0]}};
        st_wstrb = NB'(3) << {st_offset[OFF_W-1:1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_raw[int'(ld_offset) * 8 +: 8];
    ld_half = ld_raw[int'(ld_offset[OFF_W-1:1]) * 16 +: 16];
    case (ld_func3)
      F3_B:    ld_data = {{(XLEN - 8){ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {{(XLEN - 8){1'b0}}, ld_byte};
      F3_H:    ld_data = {{(XLEN - 16){ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {{(XLEN - 16){1'b0}}, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/stage_mem_lsu.sv
// Memory stage LSU: scalar and matrix-row loads/stores over a handshaked XLEN data port.
// state | meaning
// IDLE  | waiting for a valid load/store; BUSY | issuing beats until the last ack; DONE | one-cycle completion
module stage_mem_lsu
  import stage_mem_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int VLEN   = 128,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                me_valid,
  input  logic                me_mem_read,
  input  logic                me_mem_write,
  input  logic                me_vec,
  input  logic [2:0]          me_func3_code,
  input  logic [ADDR_W-1:0]   me_alu_o,
  input  logic [4:0]          me_rs2,
  input  logic [XLEN-1:0]     me_regs_data2,
  input  logic [VLEN-1:0]     me_vec_wdata,
  input  logic                forward_data,
  input  logic [1:0]          wb_w_select,
  input  logic [XLEN-1:0]     w_regs_data,
  input  logic [VLEN-1:0]     w_matrix_data,
  output logic                dm_req,
  output logic                dm_we,
  output logic [ADDR_W-1:0]   dm_addr,
  output logic [XLEN-1:0]     dm_wdata,
  output logic [XLEN/8-1:0]   dm_wstrb,
  input  logic                dm_ack,
  input  logic [XLEN-1:0]     dm_rdata,
  output logic                me_stall,
  output logic                me_done,
  output logic [XLEN-1:0]     me_mem_data,
  output logic [VLEN-1:0]     me_vec_rdata
);

  localparam int NBEAT  = VLEN / XLEN;
  localparam int NBYTE  = XLEN / 8;
  localparam int OFF_W  = $clog2(NBYTE);
  localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [BEAT_W-1:0] ROW_LAST = BEAT_W'(NBEAT - 1);

  lsu_state_t        state;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_nxt;
  logic [BEAT_W-1:0] last_beat;
  logic              is_vec;
  logic [2:0]        func3_q;
  logic [OFF_W-1:0]  off_q;
  logic [VLEN-1:0]   sdata;
  logic              accept;
  logic [XLEN-1:0]   scalar_sd;
  logic [VLEN-1:0]   row_sd;
  logic [XLEN-1:0]   st_wdata;
  logic [NBYTE-1:0]  st_wstrb;
  logic [XLEN-1:0]   ld_data;
  logic              rs2_unused;

  assign rs2_unused = ^me_rs2[4:BEAT_W];
  assign accept     = (state == ST_IDLE) & me_valid & (me_mem_read | me_mem_write);
  assign me_stall   = (state == ST_BUSY) | accept;
  assign beat_nxt   = beat + BEAT_W'(1);
  assign last_beat  = is_vec ? ROW_LAST : '0;

  // Store data is resolved once at accept, so later WB bus activity cannot corrupt it.
  always_comb begin
    row_sd = forward_data ? w_matrix_data : me_vec_wdata;
    if (!forward_data)
      scalar_sd = me_regs_data2;
    else if (wb_w_select == 2'b11)
      scalar_sd = w_matrix_data[int'(me_rs2[BEAT_W-1:0]) * XLEN +: XLEN];
    else
      scalar_sd = w_regs_data;
  end

  stage_mem_lsu_align #(.XLEN(XLEN)) u_align (
    .st_func3  (me_func3_code),
    .st_offset (me_alu_o[OFF_W-1:0]),
    .st_data   (scalar_sd),
    .st_wdata  (st_wdata),
    .st_wstrb  (st_wstrb),
    .ld_func3  (func3_q),
    .ld_offset (off_q),
    .ld_raw    (dm_rdata),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      beat         <= '0;
      is_vec       <= 1'b0;
      func3_q      <= '0;
      off_q        <= '0;
      sdata        <= '0;
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= '0;
      dm_wdata     <= '0;
      dm_wstrb     <= '0;
      me_done      <= 1'b0;
      me_mem_data  <= '0;
      me_vec_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_BUSY;
            beat     <= '0;
            is_vec   <= me_vec;
            func3_q  <= me_func3_code;
            off_q    <= me_alu_o[OFF_W-1:0];
            sdata    <= row_sd;
            dm_req   <= 1'b1;
            dm_we    <= me_mem_write;
            dm_addr  <= {me_alu_o[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            dm_wdata <= me_vec ? row_sd[XLEN-1:0] : st_wdata;
            dm_wstrb <= (me_mem_write & ~me_vec) ? st_wstrb : '1;
          end
        end
        ST_BUSY: begin
          if (dm_ack) begin
            if (!dm_we) begin
              if (is_vec)
                me_vec_rdata[int'(beat) * XLEN +: XLEN] <= dm_rdata;
              else
                me_mem_data <= ld_data;
            end
            if (beat == last_beat) begin
              dm_req  <= 1'b0;
              me_done <= 1'b1;
              state   <= ST_DONE;
            end else begin
              beat     <= beat_nxt;
              dm_addr  <= dm_addr + ADDR_W'(NBYTE);
              dm_wdata <= sdata[int'(beat_nxt) * XLEN +: XLEN];
            end
          end
        end
        ST_DONE: begin
          me_done <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Randomized self-checking bench for stage_mem_lsu against a word-array memory and result model.
module tb_stage_mem_lsu;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         me_valid = 1'b0, me_mem_read = 1'b0, me_mem_write = 1'b0, me_vec = 1'b0;
  logic [2:0]   me_func3_code = '0;
  logic [31:0]  me_alu_o = '0;
  logic [4:0]   me_rs2 = '0;
  logic [31:0]  me_regs_data2 = '0;
  logic [127:0] me_vec_wdata = '0;
  logic         forward_data = 1'b0;
  logic [1:0]   wb_w_select = '0;
  logic [31:0]  w_regs_data = '0;
  logic [127:0] w_matrix_data = '0;
  logic         dm_req, dm_we;
  logic [31:0]  dm_addr, dm_wdata;
  logic [3:0]   dm_wstrb;
  logic         dm_ack = 1'b0;
  logic [31:0]  dm_rdata = '0;
  logic         me_stall, me_done;
  logic [31:0]  me_mem_data;
  logic [127:0] me_vec_rdata;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0]  mem [0:255];
  logic [31:0]  last_ld = '0;
  logic [127:0] last_row = '0;
  logic [2:0]   ld_codes [0:4];

  always #5 clk = ~clk;

  stage_mem_lsu dut (
    .clk(clk), .rst(rst), .me_valid(me_valid), .me_mem_read(me_mem_read),
    .me_mem_write(me_mem_write), .me_vec(me_vec), .me_func3_code(me_func3_code),
    .me_alu_o(me_alu_o), .me_rs2(me_rs2), .me_regs_data2(me_regs_data2),
    .me_vec_wdata(me_vec_wdata), .forward_data(forward_data), .wb_w_select(wb_w_select),
    .w_regs_data(w_regs_data), .w_matrix_data(w_matrix_data), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .me_stall(me_stall), .me_done(me_done),
    .me_mem_data(me_mem_data), .me_vec_rdata(me_vec_rdata)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] a);
    return int'((a >> 2) & 32'hFF);
  endfunction

  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] w, input int o);
    logic [31:0] b, h;
    b = (w >> (8 * o)) & 32'hFF;
    h = (w >> (16 * (o / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return b[7] ? (b | 32'hFFFFFF00) : b;
      3'b100:  return b;
      3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // Drives one access from a negedge, plays the memory with wt wait cycles per beat (-1 = random).
  task automatic run_op(input logic rd, input logic wr, input logic vec, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [4:0] rs2, input logic [31:0] rd2,
                        input logic [127:0] vwd, input logic fwd, input logic [1:0] wsel,
                        input logic [31:0] wreg, input logic [127:0] wmat, input int wt);
    int nb, o, w, stall_n, exp_stall;
    logic [31:0] base, sd, ew, ba;
    logic [127:0] sdr;
    logic [3:0] es;
    nb = vec ? 4 : 1;
    base = addr & ~32'h3;
    o = int'(addr[1:0]);
    sdr = fwd ? wmat : vwd;
    sd = !fwd ? rd2 : ((wsel == 2'b11) ? wmat[32 * int'(rs2[1:0]) +: 32] : wreg);
    if (!wr) begin
      if (vec) for (int b = 0; b < 4; b++) last_row[32 * b +: 32] = mem[idx(base + 32'(4 * b))];
      else last_ld = ld_model(f3, mem[idx(base)], o);
    end
    me_valid = 1'b1; me_mem_read = rd; me_mem_write = wr; me_vec = vec; me_func3_code = f3;
    me_alu_o = addr; me_rs2 = rs2; me_regs_data2 = rd2; me_vec_wdata = vwd;
    forward_data = fwd; wb_w_select = wsel; w_regs_data = wreg; w_matrix_data = wmat;
    #1;
    chk("accept_stall", me_stall, 1);
    stall_n = 1; exp_stall = 1;
    @(posedge clk); @(negedge clk);
    me_valid = 1'b0; me_alu_o = $urandom; me_func3_code = 3'($urandom);
    me_regs_data2 = $urandom; w_regs_data = $urandom;
    me_vec_wdata = {$urandom, $urandom, $urandom, $urandom};
    w_matrix_data = {$urandom, $urandom, $urandom, $urandom};
    for (int b = 0; b < nb; b++) begin
      w = (wt < 0) ? int'($urandom_range(0, 3)) : wt;
      ba = base + 32'(4 * b);
      if (vec) begin ew = sdr[32 * b +: 32]; es = 4'hF; end
      else if (f3 == 3'b000) begin ew = {4{sd[7:0]}}; es = 4'b0001 << o; end
      else if (f3 == 3'b001) begin ew = {2{sd[15:0]}}; es = 4'b0011 << (2 * (o / 2)); end
      else begin ew = sd; es = 4'hF; end
      for (int c = 0; c <= w; c++) begin
        chk("dm_req", dm_req, 1);
        chk("dm_addr", dm_addr, ba);
        chk("dm_we", dm_we, wr);
        if (wr) begin
          chk("dm_wdata", dm_wdata, ew);
          chk("dm_wstrb", dm_wstrb, es);
        end else chk("dm_wstrb_rd", dm_wstrb, 4'hF);
        if (me_stall) stall_n++;
        exp_stall++;
        if (c == w) begin
          dm_ack = 1'b1;
          if (wr) begin
            for (int k = 0; k < 4; k++)
              if (es[k]) mem[idx(ba)][8 * k +: 8] = ew[8 * k +: 8];
            dm_rdata = $urandom;
          end else dm_rdata = mem[idx(ba)];
        end else begin
          dm_ack = 1'b0;
          dm_rdata = $urandom;
        end
        @(posedge clk); @(negedge clk);
      end
    end
    dm_ack = 1'b0;
    chk("stall_cycles", stall_n, exp_stall);
    chk("done", me_done, 1);
    chk("done_stall", me_stall, 0);
    chk("done_req", dm_req, 0);
    chk("mem_data", me_mem_data, last_ld);
    chk("vec_rdata", me_vec_rdata, last_row);
    @(negedge clk);
    chk("done_pulse", me_done, 0);
  endtask

  initial begin
    logic [127:0] row;
    int k;
    logic [31:0] a;
    ld_codes[0] = 3'b000; ld_codes[1] = 3'b001; ld_codes[2] = 3'b010;
    ld_codes[3] = 3'b100; ld_codes[4] = 3'b101;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    repeat (2) @(negedge clk);
    chk("rst_req", dm_req, 0); chk("rst_we", dm_we, 0); chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0); chk("rst_wstrb", dm_wstrb, 0); chk("rst_done", me_done, 0);
    chk("rst_stall", me_stall, 0); chk("rst_mem_data", me_mem_data, 0);
    chk("rst_vec_rdata", me_vec_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    mem[4] = 32'hDEADBEEF;
    run_op(1, 0, 0, 3'b010, 32'h10, 0, 0, 0, 0, 0, 0, 0, 2);
    chk("lw_value", me_mem_data, 32'hDEADBEEF);
    mem[4] = 32'h80FF0000;
    run_op(1, 0, 0, 3'b000, 32'h13, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lb_value", me_mem_data, 32'hFFFFFF80);
    run_op(1, 0, 0, 3'b100, 32'h13, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("lbu_value", me_mem_data, 32'h00000080);
    run_op(1, 0, 0, 3'b001, 32'h12, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lh_value", me_mem_data, 32'hFFFF80FF);
    run_op(0, 1, 0, 3'b000, 32'h21, 0, 32'h123456AB, 0, 0, 0, 0, 0, 1);
    run_op(0, 1, 0, 3'b001, 32'h22, 0, 32'h9999BEEF, 0, 0, 0, 0, 0, 0);
    mem[16] = 1; mem[17] = 2; mem[18] = 3; mem[19] = 4;
    run_op(1, 0, 1, 3'b111, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mld_value", me_vec_rdata, 128'h00000004_00000003_00000002_00000001);
    run_op(0, 1, 0, 3'b010, 32'h30, 5'd2, 32'h11111111, 0, 1, 2'b11, 32'h22222222,
           128'h00000001_CAFEF00D_00000002_00000003, 1);
    chk("fwd_mem", mem[12], 32'hCAFEF00D);

    // Ack while idle must be ignored.
    dm_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    dm_ack = 1'b0;
    chk("idle_ack_req", dm_req, 0);
    chk("idle_ack_done", me_done, 0);

    // Reset in the middle of a row store.
    row = 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0;
    me_valid = 1'b1; me_mem_read = 1'b0; me_mem_write = 1'b1; me_vec = 1'b1;
    me_alu_o = 32'h80; forward_data = 1'b0; me_vec_wdata = row;
    @(posedge clk); @(negedge clk);
    me_valid = 1'b0;
    chk("rst_mst_addr0", dm_addr, 32'h80);
    chk("rst_mst_data0", dm_wdata, row[31:0]);
    dm_ack = 1'b1;
    mem[idx(32'h80)] = row[31:0];
    @(posedge clk); @(negedge clk);
    dm_ack = 1'b0;
    chk("rst_mst_req1", dm_req, 1);
    chk("rst_mst_addr1", dm_addr, 32'h84);
    rst = 1'b1;
    #1;
    chk("rst_mid_req", dm_req, 0);
    chk("rst_mid_stall", me_stall, 0);
    @(negedge clk);
    rst = 1'b0;
    last_ld = '0; last_row = '0;
    run_op(1, 0, 0, 3'b010, 32'h80, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("post_rst_lw", me_mem_data, row[31:0]);

    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 3));
      a = $urandom_range(0, 32'h3EF);
      case (k)
        0: run_op(1, 0, 0, ld_codes[$urandom_range(0, 4)], a, 0, 0, 0, 0, 0, 0, 0, -1);
        1: run_op(1'($urandom), 1, 0, 3'($urandom_range(0, 2)), a, 5'($urandom), $urandom,
                  0, 1'($urandom), 2'($urandom), $urandom,
                  {$urandom, $urandom, $urandom, $urandom}, -1);
        2: run_op(1, 0, 1, 3'($urandom), a, 0, 0, 0, 0, 0, 0, 0, -1);
        default: run_op(1'($urandom), 1, 1, 3'($urandom), a, 0, 0,
                        {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 2'($urandom),
                        $urandom, {$urandom, $urandom, $urandom, $urandom}, -1);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
